// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage, instruction ROM and decoder:
// field widths, reset fetch address, opcode map and fetch state encoding.
package fetch_stage_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 9;
   localparam int OPC_W   = 5;

   localparam logic [PC_W-1:0]  RESET_PC = 16'd1;
   localparam logic [OPC_W-1:0] HALT_OPC = 5'b11010;

   typedef enum logic [OPC_W-1:0] {
      OPC_ADD  = 5'b00000,
      OPC_SUB  = 5'b00001,
      OPC_AND  = 5'b00010,
      OPC_OR   = 5'b00011,
      OPC_XOR  = 5'b00100,
      OPC_LDI  = 5'b00101,
      OPC_LD   = 5'b00110,
      OPC_ST   = 5'b00111,
      OPC_JMP  = 5'b01000,
      OPC_BEQ  = 5'b01001,
      OPC_NOP  = 5'b01111,
      OPC_HALT = HALT_OPC
   } opcode_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. flush clears the slot to a bubble (instr forced
// to 0 so nothing undefined reaches decode), load captures a new fetch,
// otherwise the contents hold.
module fetch_stage_ifid_reg
   import fetch_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               load,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pc_in,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc,
   output logic               id_valid
);

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               valid_q, valid_d;

   // next-slot selection: flush beats load, default is hold
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = '0;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = instr_in;
         pc_d    = pc_in;
         valid_d = 1'b1;
      end
   end

   // register slot, async reset to an empty bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign id_instr = instr_q;
   assign id_pc    = pc_q;
   assign id_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and
// feeds the IF/ID register. Handles stall, branch redirect with flush, and
// halt detection. Optional macro FETCH_PERF_CNT_EN adds a saturating count
// of instructions delivered valid to decode.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | fetching sequentially, pc advances on each un-stalled edge
// ST_HALTED | halt opcode delivered; pc frozen, slot drained to bubble
module fetch_stage
   import fetch_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    rom_addr,
   input  logic [INSTR_W-1:0] rom_instr,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc,
   output logic               id_valid,
   output logic               halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_count
`endif
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            ifid_flush;
   logic            ifid_load;
   logic            is_halt;

   assign is_halt = (rom_instr[INSTR_W-1 -: OPC_W] == HALT_OPC);

   // next pc / state and IF/ID control; priority branch > stall > normal
   always_comb begin
      pc_d       = pc_q;
      state_d    = state_q;
      ifid_flush = 1'b0;
      ifid_load  = 1'b0;
      if (branch_taken) begin
         pc_d       = branch_target;
         state_d    = ST_RUN;
         ifid_flush = 1'b1;
      end else if (!stall) begin
         case (state_q)
            ST_RUN: begin
               ifid_load = 1'b1;
               if (is_halt) state_d = ST_HALTED;
               else         pc_d    = pc_q + PC_W'(1);
            end
            ST_HALTED: ifid_flush = 1'b1;
            default:   state_d    = ST_RUN;
         endcase
      end
   end

   // pc and state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   assign rom_addr = pc_q;
   assign halted   = (state_q == ST_HALTED);

   fetch_stage_ifid_reg u_ifid (
      .clk      (clk),
      .rst      (rst),
      .flush    (ifid_flush),
      .load     (ifid_load),
      .instr_in (rom_instr),
      .pc_in    (pc_q),
      .id_instr (id_instr),
      .id_pc    (id_pc),
      .id_valid (id_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // count edges that deliver a valid instruction, saturating at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (ifid_load && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
   end

   // counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign fetch_count = cnt_q;
`endif

endmodule
